md_unit: RTL

//  Multiply/divide controller that owns HI/LO for the pipelined MIPS core.
//  - Sequences mult/multu/div/divu as fixed-latency multi-cycle operations and executes mthi/mtlo.
//  - Produces the stall the hazard unit uses to hold the D stage while HI/LO are busy.
//  - Sits in the E stage beside the ALU.

---
 rtl/md_unit.sv | 76 +++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div controller owning HI/LO, with D-stage stall generation
module md_unit #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             md_read,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo, am, bm, qm, rm, res_hi, res_lo;
  logic [2*WIDTH-1:0] ax, bx, prod;
  logic pend_we, issue, sg, dz, idle_start;
  assign idle_start = state == IDLE && start && !reset;
  assign issue = idle_start && md_op <= 3'd3;
  always_comb begin
    sg = ~md_op[0];
    ax = {{WIDTH{sg & src_a[WIDTH-1]}}, src_a};
    bx = {{WIDTH{sg & src_b[WIDTH-1]}}, src_b};
    prod = ax * bx;
    am = (sg && src_a[WIDTH-1]) ? -src_a : src_a;
    bm = (sg && src_b[WIDTH-1]) ? -src_b : src_b;
    dz = src_b == '0;
    qm = dz ? '0 : am / bm;
    rm = dz ? '0 : am % bm;
    res_hi = md_op[1] ? ((sg && src_a[WIDTH-1]) ? -rm : rm) : prod[2*WIDTH-1:WIDTH];
    res_lo = md_op[1] ? ((sg && (src_a[WIDTH-1] ^ src_b[WIDTH-1])) ? -qm : qm) : prod[WIDTH-1:0];
  end
  always_comb begin
    state_n = state == IDLE ? (issue ? BUSY : IDLE) : (cnt == CW'(1) ? IDLE : BUSY);
  end
  always_comb begin
    busy = state == BUSY;
    stall = md_read & (busy | (start & (md_op <= 3'd3)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      if (issue) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_we <= ~(md_op[1] & dz);
        cnt <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (busy) begin
        cnt <= cnt - CW'(1);
      end
      if (busy && cnt == CW'(1) && pend_we) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (idle_start && md_op == 3'd4) hi <= src_a;
      if (idle_start && md_op == 3'd5) lo <= src_a;
    end
  end
endmodule
